// File: rtl/seq_signed_divider.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes, one quotient bit per clock.
// Optional DIV_OVF_FLAG_EN adds an ovf output for divide-by-zero and most-negative / -1.
module seq_signed_divider #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder
`ifdef DIV_OVF_FLAG_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [n-1:0]  qsh;    // dividend magnitude shifts out the top, quotient bits shift in the bottom
  logic [n-1:0]  prem;   // partial remainder, always < |divisor| <= 2^(n-1)
  logic [n:0]    dmag;   // |divisor|, one extra bit so -2^(n-1) is exact
  logic [n-1:0]  a_q;
  logic          sa, sq;
`ifdef DIV_OVF_FLAG_EN
  localparam logic [n-1:0] MINV = {1'b1, {(n-1){1'b0}}};
  logic          sb;
`endif

  logic [n-1:0] amag;
  logic [n:0]   vmag;
  logic [n:0]   rsh;
  logic [n-1:0] rdiff;
  logic         ge;

  always_comb begin
    amag  = dividend[n-1] ? (~dividend + 1'b1) : dividend;
    vmag  = divisor[n-1] ? (~{1'b1, divisor} + 1'b1) : {1'b0, divisor};
    rsh   = {prem, qsh[n-1]};
    ge    = (rsh >= dmag);
    // true difference is below 2^(n-1), so the low n bits are exact
    rdiff = rsh[n-1:0] - dmag[n-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      qsh       <= '0;
      prem      <= '0;
      dmag      <= '0;
      a_q       <= '0;
      sa        <= 1'b0;
      sq        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_OVF_FLAG_EN
      sb        <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= dividend;
            sa    <= dividend[n-1];
            sq    <= dividend[n-1] ^ divisor[n-1];
            qsh   <= amag;
            dmag  <= vmag;
            prem  <= '0;
            cnt   <= CW'(n-1);
            busy  <= 1'b1;
            state <= CALC;
`ifdef DIV_OVF_FLAG_EN
            sb    <= divisor[n-1];
            ovf   <= 1'b0;
`endif
          end
        end
        CALC: begin
          prem <= ge ? rdiff : rsh[n-1:0];
          qsh  <= {qsh[n-2:0], ge};
          if (cnt == '0) state <= SIGN;
          else           cnt   <= cnt - 1'b1;
        end
        SIGN: begin
          // divide-by-zero runs the full CALC schedule and is overridden here
          if (dmag == '0) begin
            quotient  <= '1;
            remainder <= a_q;
          end else begin
            quotient  <= sq ? (~qsh + 1'b1) : qsh;
            remainder <= sa ? (~prem + 1'b1) : prem;
          end
`ifdef DIV_OVF_FLAG_EN
          ovf   <= (dmag == '0) || (a_q == MINV && sb && dmag == {{n{1'b0}}, 1'b1});
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
